// File: rtl/concore_pkg.sv
// Shared types and constants for the concore node poll scheduler.
package concore_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_READ    = 3'd2,
        ST_CHECK   = 3'd3,
        ST_COMPUTE = 3'd4,
        ST_WRITE   = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    localparam logic [15:0] STALE_MAX = 16'hFFFF;

    // Port-index width: clog2 of the port count, never narrower than one bit.
    function automatic int port_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/concore_poll_sched_if.sv
// Channel read, compute and write handshakes of one concore node.
interface concore_poll_sched_if
    import concore_pkg::*;
#(
    parameter int NPORTS = 2,
    parameter int TW     = 32
) ();

    localparam int PW = port_w(NPORTS);

    logic [NPORTS-1:0]    rd_req;
    logic [NPORTS-1:0]    rd_ack;
    logic [NPORTS-1:0]    rd_empty;
    logic [NPORTS*TW-1:0] rd_time;
    logic                 comp_start;
    logic [PW-1:0]        comp_port;
    logic                 comp_done;
    logic                 wr_req;
    logic                 wr_ack;

    modport master (
        output rd_req, comp_start, comp_port, wr_req,
        input  rd_ack, rd_empty, rd_time, comp_done, wr_ack
    );

    modport slave (
        input  rd_req, comp_start, comp_port, wr_req,
        output rd_ack, rd_empty, rd_time, comp_done, wr_ack
    );

endinterface

// File: rtl/concore_rr_ptr.sv
// Round-robin port pointer: steps by one on adv, wraps after the last port.
module concore_rr_ptr #(
    parameter int NPORTS = 2,
    parameter int PW     = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          adv,
    output logic [PW-1:0] ptr
);

    // Pointer register, modulo NPORTS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= {PW{1'b0}};
        end else if (adv) begin
            if (ptr == PW'(NPORTS - 1)) begin
                ptr <= {PW{1'b0}};
            end else begin
                ptr <= ptr + PW'(1);
            end
        end
    end

endmodule

// File: rtl/concore_poll_sched.sv
// Read -> compute -> write sequencer for one concore node with simtime tracking.
module concore_poll_sched
    import concore_pkg::*;
#(
    parameter int NPORTS   = 2,
    parameter int TW       = 32,
    parameter int POLL_DIV = 100,
    parameter int MAXTIME  = 10000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    concore_poll_sched_if.master     bus,
    output logic [TW-1:0]            cur_time,
    output logic [15:0]              stale_cnt,
    output logic                     finished
);

    localparam int              PW         = port_w(NPORTS);
    localparam int              TMW        = $clog2(POLL_DIV);
    localparam logic [TMW-1:0]  TIMER_LAST = TMW'(POLL_DIV - 1);
    localparam logic [TW-1:0]   TIME_LIMIT = TW'(MAXTIME);

    state_t            state_r, state_s;
    logic [TMW-1:0]    timer_r;
    logic [PW-1:0]     rr_s;
    logic              adv_s;
    logic              cap_empty_r;
    logic [TW-1:0]     cap_time_r;
    logic [TW-1:0]     last_time_r [NPORTS];
    logic [PW-1:0]     comp_port_r;
    logic [TW-1:0]     cur_time_r;
    logic [15:0]       stale_cnt_r;
    logic              ack_s;
    logic              new_data_s;
    logic [TW-1:0]     wr_time_s;
    logic [NPORTS-1:0] rd_req_s;
    logic              comp_start_s;
    logic [PW-1:0]     comp_port_s;
    logic              wr_req_s;
    logic              finished_s;

    // Where the block goes once an exchange (or a stale poll) has finished.
    function automatic state_t post_op(input logic [TW-1:0] t, input logic en_v);
        if (t >= TIME_LIMIT) begin
            return ST_DONE;
        end else if (!en_v) begin
            return ST_IDLE;
        end else begin
            return ST_WAIT;
        end
    endfunction

    concore_rr_ptr #(.NPORTS(NPORTS), .PW(PW)) u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (adv_s),
        .ptr   (rr_s)
    );

    // Datapath decisions: ack on the selected port, freshness test, max-time merge.
    always_comb begin
        ack_s      = bus.rd_ack[rr_s];
        new_data_s = !cap_empty_r && (cap_time_r > last_time_r[rr_s]);
        if (last_time_r[comp_port_r] > cur_time_r) begin
            wr_time_s = last_time_r[comp_port_r];
        end else begin
            wr_time_s = cur_time_r;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; handshakes always complete before en is honoured.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:    if (en) state_s = ST_WAIT; else state_s = ST_IDLE;
            ST_WAIT:    if (timer_r == TIMER_LAST) state_s = ST_READ; else state_s = ST_WAIT;
            ST_READ:    if (ack_s) state_s = ST_CHECK; else state_s = ST_READ;
            ST_CHECK:   if (new_data_s) state_s = ST_COMPUTE; else state_s = post_op(cur_time_r, en);
            ST_COMPUTE: if (bus.comp_done) state_s = ST_WRITE; else state_s = ST_COMPUTE;
            ST_WRITE:   if (bus.wr_ack) state_s = post_op(wr_time_s, en); else state_s = ST_WRITE;
            ST_DONE:    state_s = ST_DONE;
            default:    state_s = ST_IDLE;
        endcase
    end

    // Moore outputs; comp_port shows the triggering port during the start pulse.
    always_comb begin
        rd_req_s     = {NPORTS{1'b0}};
        comp_start_s = 1'b0;
        comp_port_s  = comp_port_r;
        wr_req_s     = 1'b0;
        finished_s   = 1'b0;
        adv_s        = 1'b0;
        case (state_r)
            ST_READ:  rd_req_s[rr_s] = 1'b1;
            ST_CHECK: begin
                adv_s = 1'b1;
                if (new_data_s) begin
                    comp_start_s = 1'b1;
                    comp_port_s  = rr_s;
                end else begin
                    comp_start_s = 1'b0;
                end
            end
            ST_WRITE: wr_req_s   = 1'b1;
            ST_DONE:  finished_s = 1'b1;
            default:  adv_s      = 1'b0;
        endcase
    end

    assign bus.rd_req     = rd_req_s;
    assign bus.comp_start = comp_start_s;
    assign bus.comp_port  = comp_port_s;
    assign bus.wr_req     = wr_req_s;
    assign finished       = finished_s;
    assign cur_time       = cur_time_r;
    assign stale_cnt      = stale_cnt_r;

    // Poll period timer, runs only while waiting and restarts each period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_r <= {TMW{1'b0}};
        end else if ((state_r == ST_WAIT) && (timer_r != TIMER_LAST)) begin
            timer_r <= timer_r + TMW'(1);
        end else begin
            timer_r <= {TMW{1'b0}};
        end
    end

    // Capture the acked port's empty flag and simtime stamp.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_empty_r <= 1'b0;
            cap_time_r  <= {TW{1'b0}};
        end else if ((state_r == ST_READ) && ack_s) begin
            cap_empty_r <= bus.rd_empty[rr_s];
            cap_time_r  <= bus.rd_time[rr_s*TW +: TW];
        end
    end

    // Per-port last-seen simtime and the port that triggered compute.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NPORTS; p++) begin
                last_time_r[p] <= {TW{1'b0}};
            end
            comp_port_r <= {PW{1'b0}};
        end else if ((state_r == ST_CHECK) && new_data_s) begin
            last_time_r[rr_s] <= cap_time_r;
            comp_port_r       <= rr_s;
        end
    end

    // Node simtime advances when the output write completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_time_r <= {TW{1'b0}};
        end else if ((state_r == ST_WRITE) && bus.wr_ack) begin
            cur_time_r <= wr_time_s;
        end
    end

    // Saturating count of polls that found nothing new.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stale_cnt_r <= 16'd0;
        end else if ((state_r == ST_CHECK) && !new_data_s && (stale_cnt_r != STALE_MAX)) begin
            stale_cnt_r <= stale_cnt_r + 16'd1;
        end
    end

endmodule

// File: tb/tb_concore_poll_sched.sv
// Directed scoreboard bench for concore_poll_sched (NPORTS=2, POLL_DIV=4, MAXTIME=10).
module tb_concore_poll_sched;

    localparam int NP = 2;
    localparam int TWB = 32;
    localparam int PDIV = 4;

    typedef struct packed {
        logic        start;
        logic [31:0] port;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [31:0] cur_time;
    logic [15:0] stale_cnt;
    logic        finished;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m_last [NP];
    logic [31:0] m_cur;
    int          m_stale;
    exp_t        q_chk [$];
    logic [31:0] q_time [$];

    concore_poll_sched_if #(.NPORTS(NP), .TW(TWB)) bus ();

    concore_poll_sched #(
        .NPORTS(NP), .TW(TWB), .POLL_DIV(PDIV), .MAXTIME(10)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .bus       (bus),
        .cur_time  (cur_time),
        .stale_cnt (stale_cnt),
        .finished  (finished)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // mode: 0 plain, 1 comp_done only in CHECK cycle, 2 drop en in COMPUTE,
    //       3 reset while wr_req is high, 4 spurious ack on the other port first
    task automatic do_poll(input int port, input bit empty, input logic [31:0] t,
                           input int lat, input int mode);
        int          n;
        logic [1:0]  onehot;
        exp_t        e;
        logic [31:0] et;
        n = 0;
        while (bus.rd_req === 2'b00 && n < 400) begin
            tick();
            n++;
        end
        onehot = 2'b01 << port;
        chk("rd_req", 32'(bus.rd_req), 32'(onehot));
        if (lat >= 0) chk("poll_latency", 32'(n), 32'(lat));
        if (mode == 4) begin
            bus.rd_ack = ~onehot;
            bus.rd_time[(1 - port)*32 +: 32] = 32'd99;
            tick();
            bus.rd_ack = 2'b00;
            chk("rd_req_after_foreign_ack", 32'(bus.rd_req), 32'(onehot));
        end
        e.start = !empty && (t > m_last[port]);
        e.port  = 32'(port);
        q_chk.push_back(e);
        bus.rd_ack   = onehot;
        bus.rd_empty = empty ? onehot : 2'b00;
        bus.rd_time[port*32 +: 32] = t;
        tick();
        bus.rd_ack   = 2'b00;
        bus.rd_empty = 2'b00;
        e = q_chk.pop_front();
        chk("comp_start", 32'(bus.comp_start), 32'(e.start));
        chk("rd_req_in_check", 32'(bus.rd_req), 32'd0);
        if (!e.start) begin
            m_stale++;
            tick();
            chk("stale_cnt", 32'(stale_cnt), 32'(m_stale));
            chk("cur_time_stale", cur_time, m_cur);
            return;
        end
        chk("comp_port", 32'(bus.comp_port), e.port);
        m_last[port] = t;
        if (mode == 1) bus.comp_done = 1'b1;
        tick();
        bus.comp_done = 1'b0;
        chk("comp_start_pulse", 32'(bus.comp_start), 32'd0);
        chk("wr_req_compute", 32'(bus.wr_req), 32'd0);
        if (mode == 2) en = 1'b0;
        if (mode == 1) begin
            tick();
            chk("early_done_ignored", 32'(bus.wr_req), 32'd0);
        end
        bus.comp_done = 1'b1;
        tick();
        bus.comp_done = 1'b0;
        chk("wr_req", 32'(bus.wr_req), 32'd1);
        tick();
        chk("wr_req_held", 32'(bus.wr_req), 32'd1);
        if (mode == 3) begin
            rst_n = 1'b0;
            #1;
            chk("rst_wr_req", 32'(bus.wr_req), 32'd0);
            chk("rst_cur_time", cur_time, 32'd0);
            chk("rst_stale_cnt", 32'(stale_cnt), 32'd0);
            chk("rst_finished", 32'(finished), 32'd0);
            m_last[0] = 32'd0;
            m_last[1] = 32'd0;
            m_cur     = 32'd0;
            m_stale   = 0;
            tick();
            rst_n = 1'b1;
            return;
        end
        q_time.push_back((m_last[port] > m_cur) ? m_last[port] : m_cur);
        bus.wr_ack = 1'b1;
        tick();
        bus.wr_ack = 1'b0;
        et = q_time.pop_front();
        m_cur = et;
        chk("cur_time", cur_time, et);
        chk("wr_req_dropped", 32'(bus.wr_req), 32'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        en            = 1'b0;
        bus.rd_ack    = 2'b00;
        bus.rd_empty  = 2'b00;
        bus.rd_time   = 64'd0;
        bus.comp_done = 1'b0;
        bus.wr_ack    = 1'b0;
        m_last[0] = 32'd0;
        m_last[1] = 32'd0;
        m_cur     = 32'd0;
        m_stale   = 0;
        tick();
        tick();
        chk("reset_rd_req", 32'(bus.rd_req), 32'd0);
        chk("reset_comp_start", 32'(bus.comp_start), 32'd0);
        chk("reset_comp_port", 32'(bus.comp_port), 32'd0);
        chk("reset_wr_req", 32'(bus.wr_req), 32'd0);
        chk("reset_cur_time", cur_time, 32'd0);
        chk("reset_stale_cnt", 32'(stale_cnt), 32'd0);
        chk("reset_finished", 32'(finished), 32'd0);
        rst_n = 1'b1;
        repeat (6) tick();
        chk("idle_no_req", 32'(bus.rd_req), 32'd0);

        en = 1'b1;
        do_poll(0, 1'b0, 32'd5,  PDIV + 1, 1);
        do_poll(1, 1'b0, 32'd2,  PDIV,     0);
        do_poll(0, 1'b0, 32'd5,  PDIV,     4);
        do_poll(1, 1'b0, 32'd1,  PDIV,     0);
        do_poll(0, 1'b0, 32'd3,  PDIV,     0);
        do_poll(1, 1'b1, 32'd99, PDIV,     0);
        do_poll(0, 1'b0, 32'd6,  PDIV,     0);
        do_poll(1, 1'b0, 32'd3,  PDIV,     0);
        do_poll(0, 1'b0, 32'd8,  PDIV,     2);
        for (int i = 0; i < 20; i++) begin
            chk("parked_no_req", 32'(bus.rd_req), 32'd0);
            tick();
        end
        en = 1'b1;
        do_poll(1, 1'b0, 32'd4,  PDIV + 1, 0);
        do_poll(0, 1'b0, 32'd9,  PDIV,     3);
        do_poll(0, 1'b0, 32'd3,  PDIV + 1, 0);
        do_poll(1, 1'b0, 32'd12, PDIV,     0);
        chk("finished", 32'(finished), 32'd1);
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("done_no_req", 32'({bus.rd_req, bus.wr_req}), 32'd0);
        end
        chk("finished_sticky", 32'(finished), 32'd1);
        chk("final_cur_time", cur_time, 32'd12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/concore_poll_sched.md
Name: concore_poll_sched

Overview:
- Synthesizable controller that sequences one concore node's read → compute → write exchange.
- Polls NPORTS input channels round-robin on a fixed period and detects a new message by an advanced simtime stamp.
- On a new message it starts the compute datapath, then issues the output write handshake.
- Tracks global simtime and stops the node at a time limit. Sits between the channel read/write adapters and the node's compute unit.

Parameters:
- NPORTS, 2, number of input channels polled (1..8)
- TW, 32, simtime width in bits (unsigned)
- POLL_DIV, 100, clock cycles between poll starts (≥2)
- MAXTIME, 10000, simtime at or above which the node finishes

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  scheduler enable
- rd_req  out  NPORTS  one-hot read request, held until acked
- rd_ack  in  NPORTS  read complete; qualifies rd_empty/rd_time of the same port
- rd_empty  in  NPORTS  channel has no message (file absent)
- rd_time  in  NPORTS*TW  per-port simtime stamp, port p at [p*TW +: TW]
- comp_start  out  1  one-cycle compute start pulse
- comp_port  out  $clog2(NPORTS) (min 1)  port whose message triggered compute
- comp_done  in  1  compute finished (pulse or level)
- wr_req  out  1  output write request, held until acked
- wr_ack  in  1  write complete
- cur_time  out  TW  current node simtime
- stale_cnt  out  16  saturating count of polls with no new data
- finished  out  1  sticky; node reached MAXTIME

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0; comp_port 0.
  - last_time[] = 0; poll timer = 0; rr pointer = 0; state IDLE.
  - Takes effect mid-handshake; in-flight requests drop immediately.
- FSM states: IDLE, WAIT, READ, CHECK, COMPUTE, WRITE, DONE.
- IDLE: if en=1 → WAIT; timer cleared.
- WAIT: timer counts up; on timer = POLL_DIV-1 → READ, timer cleared. First poll is therefore POLL_DIV cycles after leaving IDLE.
- READ:
  - rd_req[rr] asserted; all other bits 0.
  - On rd_ack[rr]: capture rd_empty[rr] and rd_time slice into regs → CHECK.
  - rd_ack on non-selected ports is ignored.
- CHECK (one cycle):
  - New data: !empty && captured_time > last_time[rr] (unsigned).
  - New data: last_time[rr] ← captured_time; comp_port ← rr; comp_start=1 this cycle → COMPUTE.
  - Otherwise: stale_cnt+1 (saturate at 0xFFFF) → post-op.
  - rr advances modulo NPORTS in this cycle in both cases.
- COMPUTE: wait comp_done=1 → WRITE. comp_done seen in the same cycle as comp_start is not accepted (earliest accepted is the next cycle).
- WRITE:
  - wr_req=1 until wr_ack.
  - On ack: cur_time ← max(cur_time, last_time[comp_port]) → post-op.
- Post-op:
  - cur_time ≥ MAXTIME → DONE.
  - Else en=0 → IDLE.
  - Else → WAIT.
  - en falling mid-READ/COMPUTE/WRITE never aborts a handshake; the block parks only at post-op.
- DONE: finished=1, absorbing until reset; no requests issued; en ignored.
- Latency:
  - Poll start to rd_req: 0 cycles (same state entry).
  - rd_ack to comp_start: 1 cycle.
  - wr_ack to next rd_req: POLL_DIV cycles when en stays 1.
- Simtime equal to last_time counts as stale (no re-trigger on a duplicate message). A decreasing time is also stale.
- Timer, rr and stale_cnt wrap/saturate exactly as stated; there are no other counters.

Decomposition:
- Shared package concore_pkg:
  - state enum type.
  - Localparam helper for port-index width (clog2 with minimum 1).
  - Constant STALE_MAX = 16'hFFFF.
- One natural sub-module, concore_rr_ptr: round-robin pointer with an advance input, modulo NPORTS, async active-low reset.

Test Plan:
- Reset then en=1, NPORTS=2, POLL_DIV=4:
  - rd_req=01 exactly 4 cycles after IDLE exit.
  - Ack with rd_time=5 → comp_start 1 cycle later, comp_port=0.
  - comp_done, wr_ack → cur_time=5.
  - Next poll targets port 1 (rd_req=10).
- Port 0 acked twice with rd_time=5 → second poll gives no comp_start; stale_cnt=1. rd_time=3 → stale_cnt=2.
- rd_empty=1 with rd_time=99 on ack → treated as stale; last_time[] and cur_time unchanged.
- MAXTIME=10:
  - Port 1 delivers 12 → after wr_ack, finished=1.
  - No further rd_req for 50 cycles even with en=1.
- en dropped during COMPUTE:
  - comp_done and wr_ack still complete; block returns to IDLE with no rd_req.
  - Re-assert en → poll resumes after POLL_DIV cycles.
- rst_n pulsed low while wr_req=1 → wr_req, cur_time, stale_cnt, finished all 0 asynchronously; after release, the first poll targets port 0.
